// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame width and the
// bit-period helper used by both the RX and TX sides.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_rx_state_e;

  // Clock cycles per bit, truncated.
  function automatic int uart_bit_cycles(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rxd pin, plus a delayed copy
// of the synchronised line for falling-edge detection.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Reset to the idle (high) line level so that reset release never looks
  // like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value of
      // its predecessor, which is what turns these three lines into a shift chain.
      r_meta <= rxd;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rxd_s = r_sync;
  assign fall  = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit validation, centre sampling with a
// restartable bit timer, one-cycle valid / framing-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  output logic                      rx_frame_err,
  output logic                      rx_busy
);

  localparam int BIT_CYCLES  = uart_bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int TW          = $clog2(BIT_CYCLES + 1);
  localparam int IW          = $clog2(UART_DATA_BITS);

  localparam logic [TW-1:0] BIT_T    = TW'(BIT_CYCLES);
  localparam logic [TW-1:0] HALF_T   = TW'(HALF_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(UART_DATA_BITS - 1);

  if (BIT_CYCLES < 4) begin : g_bad_baud
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end

  logic w_rxd_s;
  logic w_fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .rxd_s (w_rxd_s),
    .fall  (w_fall)
  );

  uart_rx_state_e            r_state;
  uart_rx_state_e            w_state_next;
  logic [TW-1:0]             r_timer;
  logic [IW-1:0]             r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_valid;
  logic                      r_frame_err;

  logic w_at_half;
  logic w_at_bit;
  logic w_restart;
  logic w_shift;
  logic w_good;
  logic w_bad;

  assign w_at_half = (r_timer == HALF_T);
  assign w_at_bit  = (r_timer == BIT_T);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    w_state_next = r_state;
    w_restart    = 1'b0;
    w_shift      = 1'b0;
    w_good       = 1'b0;
    w_bad        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_next = S_START;
          w_restart    = 1'b1;
        end
      end
      S_START: begin
        if (w_at_half) begin
          w_restart    = 1'b1;
          w_state_next = w_rxd_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_at_bit) begin
          w_restart = 1'b1;
          w_shift   = 1'b1;
          if (r_bit_idx == LAST_IDX) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_at_bit) begin
          w_state_next = S_IDLE;
          w_good       = w_rxd_s;
          w_bad        = ~w_rxd_s;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // The cycle that triggers a restart is tick 0 of the new interval, so the
  // timer reloads to 1 and the sample lands exactly on the compare value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_state_next == S_IDLE) r_timer <= '0;
      else if (w_restart)         r_timer <= TW'(1);
      else                        r_timer <= r_timer + TW'(1);

      if (r_state == S_START) r_bit_idx <= '0;
      else if (w_shift)       r_bit_idx <= r_bit_idx + IW'(1);

      if (w_shift) r_shift <= {w_rxd_s, r_shift[UART_DATA_BITS-1:1]};
      if (w_good)  r_data  <= r_shift;

      r_valid     <= w_good;
      r_frame_err <= w_bad;
    end
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_frame_err = r_frame_err;
  assign rx_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialised from a byte-level model,
// expected strobes are queued and a monitor compares them as they appear.
module tb_uart_rx;

  localparam int BIT      = 217;
  localparam int STROBE_D = 2 + 108 + 9 * BIT + 1;  // pin edge -> strobe cycle

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         edge_cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx #(.CLK_FREQ(25_000_000), .BAUD_RATE(115200)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  exp_t       exp_q[$];
  int         n_tests   = 0;
  int         n_fail    = 0;
  int         n_pushed  = 0;
  int         n_strobes = 0;
  int         cyc       = 0;
  logic [7:0] last_good = 8'h00;
  bit         prev_strobe = 1'b0;

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid || rx_frame_err) begin
        exp_t e;
        int   d;
        n_strobes++;
        check("strobe_exclusive", 32'(rx_valid & rx_frame_err), 0);
        if (prev_strobe) begin
          n_tests++;
          n_fail++;
          $display("FAIL strobe_width: strobe high in consecutive cycles at %0d, required 1 cycle", cyc);
        end
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: valid=%0b ferr=%0b data=0x%0h at cycle %0d, required none",
                   rx_valid, rx_frame_err, rx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          d = cyc - e.edge_cyc;
          check("strobe_kind_ferr", 32'(rx_frame_err), 32'(e.is_err));
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("strobe_delay", d, (d == STROBE_D + 1) ? STROBE_D + 1 : STROBE_D);
        end
      end
      prev_strobe = rx_valid || rx_frame_err;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  // Serialise one 8N1 frame with bit period p; queue the expected outcome.
  task automatic send_frame(input logic [7:0] d, input bit stop, input int p);
    exp_t e;
    e.edge_cyc = cyc;
    e.is_err   = !stop;
    if (stop) last_good = d;
    e.data = last_good;
    exp_q.push_back(e);
    n_pushed++;
    rxd = 1'b0;
    repeat (p) tick();
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (p) tick();
    end
    rxd = stop;
    repeat (p) tick();
  endtask

  initial begin
    int n0;
    rst_n = 1'b1;
    rxd   = 1'b1;
    #5 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", 32'(rx_data), 0);
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_rx_frame_err", 32'(rx_frame_err), 0);
    check("reset_rx_busy", 32'(rx_busy), 0);
    #5 rst_n = 1'b1;
    tick();
    idle(2500);
    check("idle_busy_mid", 32'(rx_busy), 0);
    idle(2500);
    check("idle_busy_end", 32'(rx_busy), 0);

    // Single good frame.
    send_frame(8'hA5, 1'b1, BIT);
    idle(100);

    // Start-bit glitch: low for 50 cycles only.
    n0  = cyc;
    rxd = 1'b0;
    tick();
    tick();
    check("glitch_busy_at_E", 32'(rx_busy), 0);
    tick();
    check("glitch_busy_at_E1", 32'(rx_busy), 1);
    while (cyc < n0 + 50) tick();
    rxd = 1'b1;
    while (cyc < n0 + 2 + 108) tick();
    check("glitch_busy_at_sample", 32'(rx_busy), 1);
    tick();
    check("glitch_busy_after_sample", 32'(rx_busy), 0);
    idle(200);
    check("glitch_rx_data", 32'(rx_data), 32'(last_good));

    // Framing error, then the line stays low for three bit times.
    send_frame(8'h3C, 1'b0, BIT);
    repeat (3 * BIT) tick();
    check("held_low_busy", 32'(rx_busy), 0);
    check("held_low_rx_data", 32'(rx_data), 32'(last_good));
    idle(300);
    send_frame(8'hC3, 1'b1, BIT);
    idle(50);

    // Back-to-back frames, zero idle.
    send_frame(8'h00, 1'b1, BIT);
    send_frame(8'hFF, 1'b1, BIT);
    send_frame(8'h5A, 1'b1, BIT);
    idle(100);
    check("b2b_rx_data", 32'(rx_data), 32'h5A);

    // Reset during data bit 4 of 0x81.
    rxd = 1'b0;
    repeat (BIT) tick();
    for (int i = 0; i < 4; i++) begin
      rxd = (i == 0);
      repeat (BIT) tick();
    end
    rxd = 1'b0;
    repeat (100) tick();
    #7 rst_n = 1'b0;
    #1;
    check("midreset_rx_data", 32'(rx_data), 0);
    check("midreset_rx_busy", 32'(rx_busy), 0);
    check("midreset_rx_valid", 32'(rx_valid), 0);
    check("midreset_rx_frame_err", 32'(rx_frame_err), 0);
    last_good = 8'h00;
    rxd = 1'b1;
    repeat (5) tick();
    rst_n = 1'b1;
    idle(200);
    send_frame(8'h55, 1'b1, BIT);
    idle(100);
    check("post_reset_rx_data", 32'(rx_data), 32'h55);

    // Randomised frames: data, stop bit, bit period (about +/-1.8 %) and gap.
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      bit         stop;
      int         p;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      p    = $urandom_range(213, 221);
      send_frame(d, stop, p);
      idle(stop ? $urandom_range(0, 200) : $urandom_range(20, 200));
    end

    idle(2500);
    check("queue_empty", exp_q.size(), 0);
    check("strobe_count", n_strobes, n_pushed);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 serial frames. It is the receive-side counterpart of the transmit path driven by `baud_pulse_gen`. The block synchronises the asynchronous `rxd` pin, detects and validates the start bit, and samples each bit at its centre using its own restartable bit timer. Each received byte is presented as a one-cycle valid strobe; a bad stop bit is flagged as a framing error. It sits between the board RX pin and the command/LED logic.

## Interface
Parameters:
- `CLK_FREQ`, 25_000_000, clock frequency in Hz.
- `BAUD_RATE`, 115200, line rate in bit/s.

Ports:
- `clk`  input  1  system clock.
- `rst_n`  input  1  asynchronous, active-low reset; one clock domain only.
- `rxd`  input  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  output  8  last correctly received byte, LSB first on the line.
- `rx_valid`  output  1  one-cycle strobe: `rx_data` has just been updated.
- `rx_frame_err`  output  1  one-cycle strobe: stop bit sampled low.
- `rx_busy`  output  1  high while a frame is in progress.

## Operation
- Derived constants, with integer truncation:
  - `BIT_CYCLES = CLK_FREQ/BAUD_RATE` (217 at the defaults).
  - `HALF_CYCLES = BIT_CYCLES/2` (108 at the defaults).
  - Elaboration must fail if `BIT_CYCLES < 4`.
- Input synchroniser: two flops, both reset to 1. `rxd_s` is the second flop output. A third flop holds `rxd_s` delayed, for edge detection.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge of `rxd_s` (previous 1, current 0) → START, timer cleared. A held-low line never triggers; an edge is required.
  - START: at timer = `HALF_CYCLES`, sample `rxd_s`. If 0 → DATA, timer cleared, bit index 0. If 1 (glitch) → IDLE, with no output strobe.
  - DATA: at each timer = `BIT_CYCLES`, shift `rxd_s` into the MSB of the shift register (shift right) and clear the timer. After bit index 7 → STOP.
  - STOP: at timer = `BIT_CYCLES`, sample `rxd_s`, then go to IDLE.
    - If the sample is 1: `rx_data` ← shift register and pulse `rx_valid`.
    - If the sample is 0: pulse `rx_frame_err` and leave `rx_data` unchanged.
- The bit timer counts 0..`BIT_CYCLES` and is cleared on every state entry. Its width is `$clog2(BIT_CYCLES+1)`.
- `rx_valid` and `rx_frame_err` are never high in the same cycle.
- Reset mid-frame: the FSM returns to IDLE immediately and the partial byte is discarded.

## Timing
- Reset values: `rx_data` = 8'h00, `rx_valid` = 0, `rx_frame_err` = 0, `rx_busy` = 0, FSM = IDLE.
- Let E be the cycle in which the falling edge is seen on `rxd_s`. E is 2–3 clocks after the pin edge, because of the synchroniser.
- Start sample: E+`HALF_CYCLES`.
- Data bit k sample: E+`HALF_CYCLES`+(k+1)·`BIT_CYCLES`.
- Stop sample: E+`HALF_CYCLES`+9·`BIT_CYCLES`.
- `rx_valid`/`rx_frame_err`: registered, high for exactly one cycle, in the cycle after the stop sample. At the defaults this is E+2062.
- `rx_busy`: high from E+1 through the stop-sample cycle inclusive. It also drops the cycle after a failed start sample.
- A new start edge is accepted from the cycle after the stop sample. This supports back-to-back frames with zero idle time.
- Tolerated baud mismatch: ±2 % total.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (localparams `S_IDLE`, `S_START`, `S_DATA`, `S_STOP`).
  - `UART_DATA_BITS = 8`.
  - Macro/function computing `BIT_CYCLES` from `CLK_FREQ` and `BAUD_RATE`, shared with the TX side.
- One sub-module, `uart_rx_sync`: the two-flop synchroniser plus delayed copy. It outputs `rxd_s` and `fall`.
- FSM, timer, shift register and output registers live in `uart_rx`.

## Test plan
All scenarios use the defaults: 25 MHz clock, 115200 baud, 217 cycles per bit.
- Reset with `rxd`=1 → all outputs 0. After release with the line idle for 5000 cycles: no strobe, `rx_busy`=0.
- Frame 0xA5 with a good stop bit → `rx_valid` one cycle at E+2062 with `rx_data`=8'hA5; `rx_frame_err` stays 0.
- Glitch: `rxd` low for 50 cycles, then high → no strobes; `rx_busy` falls at E+109; `rx_data` unchanged.
- Frame 0x3C with stop bit 0 and the line then held low for 3 bit-times → one `rx_frame_err` pulse; `rx_data` keeps its previous value; no new frame until the line goes high and then falls again.
- Back-to-back 0x00, 0xFF, 0x5A with no idle gap → three `rx_valid` pulses, 2170 cycles apart, carrying the correct data.
- Reset asserted during data bit 4 of 0x81 → outputs return to reset values asynchronously. After release, frame 0x55 is received correctly with exactly one `rx_valid`.
